mc_core_seq: RTL and testbench
==============================

Name: mc_core_seq

Overview:
- Parametrised multi-cycle sequencer for the next-generation SCC core top.
- Replaces the implicit "everything in one cycle" timing with an explicit FETCH/DECODE/EXEC/MEM/WB state machine.
- Supports variable-latency instruction and data memories (req/ack), clock enable, halt, branch override and error reporting.
- Sits between instruction/data memory and the existing fetch/decode/execute/register datapath, gating their strobes.

Parameters:
- XLEN, 32, datapath/address width.
- TGT_W, 16, width of branch target from execute (zero-extended to XLEN).
- PC_RESET, 0, PC value after reset.
- PC_STEP, 1, PC increment per sequential instruction.
- TIMEOUT, 15, max cycles a memory request may wait for ack before error (1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  clock enable; 0 freezes all state
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  XLEN  fetched instruction
- ir  out  XLEN  latched instruction to decode
- ir_valid  out  1  one-cycle pulse in DECODE
- dec_is_mem  in  1  decoded load/store
- dec_is_store  in  1  decoded store
- dec_halt  in  1  decoded halt
- dec_illegal  in  1  decode error
- exe_override  in  1  branch taken
- exe_target  in  TGT_W  branch target
- dmem_req  out  1  data request
- dmem_we  out  1  data write (valid with dmem_req)
- dmem_ack  in  1  data access complete
- rf_we_en  out  1  register write qualifier, high only in WB
- pc  out  XLEN  program counter
- state  out  3  current state encoding
- halted  out  1  core halted
- err_bits  out  2  00 none, 01 imem timeout, 10 dmem timeout, 11 illegal
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=1 at posedge, regardless of clk_en):
  - State goes to FETCH.
  - pc=PC_RESET, ir=0, instret=0, err_bits=00.
  - All strobes (imem_req, ir_valid, dmem_req, dmem_we, rf_we_en, halted) = 0 next cycle.
  - Resetting during an outstanding request drops req; a late ack is ignored.
- clk_en=0: state, pc, ir, counters and wait counter hold. Outputs hold their current values, and ack inputs are ignored.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
- FETCH:
  - imem_req=1 and stays high until imem_ack.
  - On ack: ir<=imem_rdata, go to DECODE.
- DECODE:
  - ir_valid=1 for exactly one cycle.
  - If dec_illegal, go to ERR with err=11. Illegal has priority over halt.
  - Else if dec_halt, go to HALT.
  - Else go to EXEC.
- EXEC:
  - Samples exe_override.
  - Next pc = zero_ext(exe_target) if taken, else pc+PC_STEP (mod 2^XLEN, wraps).
  - pc itself updates on leaving WB.
  - Goes to MEM if dec_is_mem, else WB.
- MEM:
  - dmem_req=1 and dmem_we=dec_is_store, held until dmem_ack.
  - On ack, go to WB.
- WB:
  - rf_we_en=1 for one cycle.
  - pc<=next pc, instret<=instret+1 (wraps).
  - Go to FETCH.
- Latency: non-memory instruction with zero-wait memory = 4 cycles (FETCH, DECODE, EXEC, WB); memory instruction = 5 cycles. Each extra wait cycle adds 1.
- Timeout:
  - Wait counter clears on entering FETCH or MEM and increments each enabled cycle without ack.
  - When the counter reaches TIMEOUT with no ack: go to ERR, err=01 (FETCH) or 10 (MEM).
  - An ack arriving in the same cycle the limit is reached wins, and no error is raised.
- HALT: halted=1, sticky until rst; no requests issued; instret not incremented for the halt instruction.
- ERR: err_bits sticky, halted=1, all strobes 0, exit only by rst.
- An ack received while the corresponding req=0 is ignored.

Decomposition:
- Shared package mc_core_pkg:
  - state encodings (3-bit localparams)
  - err_bits codes
  - default TIMEOUT
- One sub-module, mc_wait_timer: parametrised TIMEOUT counter with clear/enable/expired.
- FSM, pc and instret live in mc_core_seq.

Test Plan:
- Zero-wait ALU instruction after rst, PC_RESET=0, ack same cycle as req → ir_valid at cycle 2, rf_we_en at cycle 4, pc=1, instret=1.
- Store with dmem_ack delayed 3 cycles → dmem_req and dmem_we held high 4 cycles, retire at cycle 8, pc=1.
- Branch with exe_override=1, exe_target=0x0040 → pc=0x40 after WB; next imem_addr=0x40.
- imem_ack never asserted, TIMEOUT=15 → ERR after 15 wait cycles, err_bits=01, halted=1, imem_req=0. Repeat with ack at exactly the 15th cycle → no error.
- dec_halt and dec_illegal both high → err_bits=11. dec_halt alone → halted=1, instret unchanged, no further imem_req.
- clk_en=0 for 5 cycles mid-MEM, then rst asserted mid-FETCH → state/pc frozen during stall; after rst, pc=PC_RESET, instret=0, late ack ignored.

Source files
------------

// File: rtl/mc_core_pkg.sv
// mc_core_pkg: shared encodings for the multi-cycle core sequencer.
// State codes, error codes and wait-timer defaults.
package mc_core_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_IMEM = 2'b01;
    localparam logic [1:0] ERR_DMEM = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    localparam int DEF_TIMEOUT = 15;
    localparam int WAIT_W      = 8;

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts cycles a memory request has waited.
// expired flags the cycle that would be the TIMEOUT-th wait.
module mc_wait_timer
    import mc_core_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [WAIT_W-1:0] count;

    // wait count, cleared outside wait states, bumped per unacked cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mc_core_seq.sv
// mc_core_seq: FETCH/DECODE/EXEC/MEM/WB sequencer with
// variable-latency memories, halt, branch override and errors.
module mc_core_seq
    import mc_core_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          TGT_W    = 16,
    parameter int unsigned PC_RESET = 0,
    parameter int unsigned PC_STEP  = 1,
    parameter int          TIMEOUT  = DEF_TIMEOUT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]  ir,
    output logic             ir_valid,
    input  logic             dec_is_mem,
    input  logic             dec_is_store,
    input  logic             dec_halt,
    input  logic             dec_illegal,
    input  logic             exe_override,
    input  logic [TGT_W-1:0] exe_target,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we_en,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       err_bits,
    output logic [CNT_W-1:0] instret
);

    logic [2:0]      curState;
    logic [2:0]      nextState;
    logic [1:0]      errCode;
    logic [XLEN-1:0] nextPc;
    logic            inWait;
    logic            waitAck;
    logic            expired;

    assign inWait  = (curState == ST_FETCH) || (curState == ST_MEM);
    assign waitAck = ((curState == ST_FETCH) && imem_ack) ||
                     ((curState == ST_MEM) && dmem_ack);

    mc_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) uTimer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clk_en && !inWait),
        .inc    (clk_en && inWait && !waitAck),
        .expired(expired)
    );

    // state register; reset wins over clock enable
    always_ff @(posedge clk) begin
        if (rst) begin
            curState <= ST_FETCH;
        end else if (clk_en) begin
            curState <= nextState;
        end
    end

    // next state and the error code raised on entering ERR
    always_comb begin
        nextState = curState;
        errCode   = ERR_NONE;
        case (curState)
            ST_FETCH: begin
                if (imem_ack) begin
                    nextState = ST_DECODE;
                end else if (expired) begin
                    nextState = ST_ERR;
                    errCode   = ERR_IMEM;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    nextState = ST_ERR;
                    errCode   = ERR_ILL;
                end else if (dec_halt) begin
                    nextState = ST_HALT;
                end else begin
                    nextState = ST_EXEC;
                end
            end
            ST_EXEC:  nextState = dec_is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack) begin
                    nextState = ST_WB;
                end else if (expired) begin
                    nextState = ST_ERR;
                    errCode   = ERR_DMEM;
                end
            end
            ST_WB:    nextState = ST_FETCH;
            ST_HALT:  nextState = ST_HALT;
            ST_ERR:   nextState = ST_ERR;
            default: begin
                nextState = ST_ERR;
                errCode   = ERR_ILL;
            end
        endcase
    end

    // strobes decoded from state, forced low while in reset
    always_comb begin
        imem_req = 1'b0;
        ir_valid = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we_en = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            case (curState)
                ST_FETCH:  imem_req = 1'b1;
                ST_DECODE: ir_valid = 1'b1;
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = dec_is_store;
                end
                ST_WB:     rf_we_en = 1'b1;
                ST_HALT:   halted = 1'b1;
                ST_ERR:    halted = 1'b1;
                default:   halted = 1'b0;
            endcase
        end
    end

    // instruction, pc, branch target, retire count and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= '0;
            pc       <= XLEN'(PC_RESET);
            nextPc   <= XLEN'(PC_RESET);
            instret  <= '0;
            err_bits <= ERR_NONE;
        end else if (clk_en) begin
            if (curState == ST_FETCH && imem_ack) begin
                ir <= imem_rdata;
            end
            if (curState == ST_EXEC) begin
                nextPc <= exe_override ? XLEN'(exe_target)
                                       : pc + XLEN'(PC_STEP);
            end
            if (curState == ST_WB) begin
                pc      <= nextPc;
                instret <= instret + CNT_W'(1);
            end
            if (curState != ST_ERR && nextState == ST_ERR) begin
                err_bits <= errCode;
            end
        end
    end

    assign imem_addr = pc;
    assign state     = curState;

endmodule

// File: tb/tb_mc_core_seq.sv
// tb_mc_core_seq: directed checks of the multi-cycle sequencer.
// Inputs change 1ns after each rising edge; outputs sampled there.
module tb_mc_core_seq;
    import mc_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        dec_is_mem;
    logic        dec_is_store;
    logic        dec_halt;
    logic        dec_illegal;
    logic        exe_override;
    logic [15:0] exe_target;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we_en;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        halted;
    logic [1:0]  err_bits;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_core_seq dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .dec_is_mem  (dec_is_mem),
        .dec_is_store(dec_is_store),
        .dec_halt    (dec_halt),
        .dec_illegal (dec_illegal),
        .exe_override(exe_override),
        .exe_target  (exe_target),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .rf_we_en    (rf_we_en),
        .pc          (pc),
        .state       (state),
        .halted      (halted),
        .err_bits    (err_bits),
        .instret     (instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clk_en = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        dec_is_mem = 1'b0;
        dec_is_store = 1'b0;
        dec_halt = 1'b0;
        dec_illegal = 1'b0;
        exe_override = 1'b0;
        exe_target = 16'h0;
        dmem_ack = 1'b0;

        // reset state
        tick();
        chk("rst_state", 32'(state), 32'(ST_FETCH));
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_err", 32'(err_bits), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_ir", ir, 32'h0);

        // zero-wait ALU instruction: cycles 1..4
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234;
        #1;
        chk("c1_req", 32'(imem_req), 32'h1);
        chk("c1_addr", imem_addr, 32'h0);
        tick();
        imem_ack = 1'b0;
        chk("c2_state", 32'(state), 32'(ST_DECODE));
        chk("c2_valid", 32'(ir_valid), 32'h1);
        chk("c2_ir", ir, 32'h1234);
        tick();
        chk("c3_state", 32'(state), 32'(ST_EXEC));
        chk("c3_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("c4_rfwe", 32'(rf_we_en), 32'h1);
        chk("c4_pc", pc, 32'h0);
        tick();
        chk("alu_pc", pc, 32'h1);
        chk("alu_instret", instret, 32'h1);
        chk("alu_state", 32'(state), 32'(ST_FETCH));
        chk("alu_rfwe", 32'(rf_we_en), 32'h0);

        // store with dmem_ack on the 4th MEM cycle
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        dec_is_mem = 1'b1;
        dec_is_store = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("st_dreq", 32'(dmem_req), 32'h1);
            chk("st_dwe", 32'(dmem_we), 32'h1);
            if (i == 3) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        dec_is_mem = 1'b0;
        dec_is_store = 1'b0;
        chk("st_wb_state", 32'(state), 32'(ST_WB));
        chk("st_rfwe", 32'(rf_we_en), 32'h1);
        chk("st_dreq_off", 32'(dmem_req), 32'h0);
        tick();
        chk("st_pc", pc, 32'h2);
        chk("st_instret", instret, 32'h2);

        // taken branch to 0x40
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        exe_override = 1'b1;
        exe_target = 16'h0040;
        tick();
        tick();
        exe_override = 1'b0;
        exe_target = 16'h0;
        chk("br_wb_pc", pc, 32'h2);
        tick();
        chk("br_pc", pc, 32'h40);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_instret", instret, 32'h3);

        // load stalled by clk_en=0 in MEM; ack during stall ignored
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        dec_is_mem = 1'b1;
        tick();
        tick();
        chk("sl_state", 32'(state), 32'(ST_MEM));
        clk_en = 1'b0;
        dmem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sl_frz_state", 32'(state), 32'(ST_MEM));
            chk("sl_frz_pc", pc, 32'h40);
            chk("sl_frz_dreq", 32'(dmem_req), 32'h1);
        end
        chk("sl_dwe", 32'(dmem_we), 32'h0);
        clk_en = 1'b1;
        tick();
        dmem_ack = 1'b0;
        dec_is_mem = 1'b0;
        chk("sl_wb", 32'(state), 32'(ST_WB));
        tick();
        chk("sl_pc", pc, 32'h41);
        chk("sl_instret", instret, 32'h4);

        // reset mid-FETCH with clk_en low and a late ack
        tick();
        rst = 1'b1;
        clk_en = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk("rr_req_drop", 32'(imem_req), 32'h0);
        tick();
        chk("rr_state", 32'(state), 32'(ST_FETCH));
        chk("rr_pc", pc, 32'h0);
        chk("rr_instret", instret, 32'h0);
        chk("rr_ir", ir, 32'h0);
        rst = 1'b0;
        clk_en = 1'b1;
        imem_ack = 1'b0;
        #1;
        chk("rr_req", 32'(imem_req), 32'h1);

        // fetch timeout: 15 unacked cycles
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("to_wait", 32'(state), 32'(ST_FETCH));
        end
        tick();
        chk("to_state", 32'(state), 32'(ST_ERR));
        chk("to_err", 32'(err_bits), 32'(ERR_IMEM));
        chk("to_halted", 32'(halted), 32'h1);
        chk("to_req", 32'(imem_req), 32'h0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("to_sticky_st", 32'(state), 32'(ST_ERR));
        chk("to_sticky_err", 32'(err_bits), 32'(ERR_IMEM));

        // ack on the 15th cycle wins over timeout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("tk_state", 32'(state), 32'(ST_DECODE));
        chk("tk_err", 32'(err_bits), 32'h0);

        // illegal beats halt
        dec_halt = 1'b1;
        dec_illegal = 1'b1;
        tick();
        dec_halt = 1'b0;
        dec_illegal = 1'b0;
        chk("il_state", 32'(state), 32'(ST_ERR));
        chk("il_err", 32'(err_bits), 32'(ERR_ILL));
        chk("il_halted", 32'(halted), 32'h1);

        // halt alone
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        dec_halt = 1'b1;
        tick();
        dec_halt = 1'b0;
        chk("h_state", 32'(state), 32'(ST_HALT));
        chk("h_halted", 32'(halted), 32'h1);
        chk("h_instret", instret, 32'h0);
        chk("h_req", 32'(imem_req), 32'h0);
        chk("h_err", 32'(err_bits), 32'h0);
        imem_ack = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        chk("h_state2", 32'(state), 32'(ST_HALT));
        chk("h_req2", 32'(imem_req), 32'h0);
        chk("h_pc", pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
